mgmt_sensor_bridge: RTL

MGMT_SENSOR_BRIDGE -- requirements
Module: mgmt_sensor_bridge

---
 rtl/mgmt_sensor_bridge.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mgmt_sensor_bridge.sv
// SPI management bridge: snapshot reads of sensor channels and
// byte-wide writes into host registers, with a protocol error counter.
module mgmt_sensor_bridge #(
   parameter int NUM_CH   = 8,
   parameter int CH_WIDTH = 16,
   parameter int NUM_WR   = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         spi_cs_falling,
   input  logic                         spi_rx_data_valid,
   input  logic [7:0]                   spi_rx_data,
   output logic                         spi_tx_data_valid,
   output logic [7:0]                   spi_tx_data,
   input  logic [NUM_CH*CH_WIDTH-1:0]   ch_data,
   output logic [NUM_WR*8-1:0]          wr_regs,
   output logic [NUM_WR-1:0]            wr_strobe,
   output logic [7:0]                   err_count
);

   localparam int BPC = CH_WIDTH / 8;
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BW  = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int WW  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

   typedef enum logic [1:0] {
      IDLE,
      OPCODE,
      READ,
      WRITE
   } state_t;

   state_t state, state_nx;

   logic [1:0] rst_sync;
   logic       rst_s;

   logic [NUM_CH*CH_WIDTH-1:0] snap;
   logic [CHW-1:0]             ch_idx;
   logic [BW-1:0]              byte_idx;
   logic                       rd_err;
   logic [WW-1:0]              wr_addr;
   logic                       wr_err;

   logic       rd_start, rd_next, wr_start, wr_byte, idle_byte;
   logic [6:0] op_addr;
   logic       rd_bad, wr_bad;

   logic [NUM_CH*CH_WIDTH-1:0] sel_vec;
   logic [CHW-1:0]             sel_ch, nx_ch;
   logic [BW-1:0]              sel_byte, nx_byte;
   logic [CH_WIDTH-1:0]        chan;
   logic [7:0]                 sel_val;
   logic [WW-1:0]              wr_addr_nx;
   logic                       err_hit;

   // Assert immediately, release two edges after rst_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_s = rst_sync[1];

   assign op_addr = spi_rx_data[6:0];
   assign rd_bad  = int'(op_addr) >= NUM_CH;
   assign wr_bad  = int'(op_addr) >= NUM_WR;

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // A cs_falling pulse wins over any byte strobe in the same cycle.
   always_comb begin
      state_nx  = state;
      rd_start  = 1'b0;
      rd_next   = 1'b0;
      wr_start  = 1'b0;
      wr_byte   = 1'b0;
      idle_byte = 1'b0;
      if (spi_cs_falling) begin
         state_nx = OPCODE;
      end else if (spi_rx_data_valid) begin
         unique case (state)
            IDLE: idle_byte = 1'b1;
            OPCODE: begin
               if (spi_rx_data[7]) begin
                  wr_start = 1'b1;
                  state_nx = WRITE;
               end else begin
                  rd_start = 1'b1;
                  state_nx = READ;
               end
            end
            READ:  rd_next = 1'b1;
            WRITE: wr_byte = 1'b1;
            default: state_nx = IDLE;
         endcase
      end
   end

   // First read byte comes from live data; the snapshot loads alongside.
   always_comb begin
      sel_vec  = rd_start ? ch_data : snap;
      sel_ch   = rd_start ? op_addr[CHW-1:0] : ch_idx;
      sel_byte = rd_start ? '0 : byte_idx;
      chan     = '0;
      sel_val  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel_ch == CHW'(i)) begin
            chan = sel_vec[i*CH_WIDTH +: CH_WIDTH];
         end
      end
      for (int b = 0; b < BPC; b++) begin
         if (sel_byte == BW'(b)) begin
            sel_val = chan[CH_WIDTH-8-8*b +: 8];
         end
      end
      nx_ch   = sel_ch;
      nx_byte = sel_byte + BW'(1);
      if (sel_byte == BW'(BPC - 1)) begin
         nx_byte = '0;
         if (sel_ch == CHW'(NUM_CH - 1)) begin
            nx_ch = '0;
         end else begin
            nx_ch = sel_ch + CHW'(1);
         end
      end
   end

   always_comb begin
      if (wr_addr == WW'(NUM_WR - 1)) begin
         wr_addr_nx = '0;
      end else begin
         wr_addr_nx = wr_addr + WW'(1);
      end
   end

   assign err_hit = idle_byte
                  | (rd_start & rd_bad)
                  | (wr_start & wr_bad);

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         spi_tx_data_valid <= 1'b0;
         spi_tx_data       <= 8'h00;
         wr_regs           <= '0;
         wr_strobe         <= '0;
         err_count         <= 8'h00;
         snap              <= '0;
         ch_idx            <= '0;
         byte_idx          <= '0;
         rd_err            <= 1'b0;
         wr_addr           <= '0;
         wr_err            <= 1'b0;
      end else begin
         spi_tx_data_valid <= 1'b0;
         wr_strobe         <= '0;
         if (rd_start) begin
            snap              <= ch_data;
            rd_err            <= rd_bad;
            spi_tx_data_valid <= 1'b1;
            spi_tx_data       <= rd_bad ? 8'h00 : sel_val;
            ch_idx            <= nx_ch;
            byte_idx          <= nx_byte;
         end
         if (rd_next) begin
            spi_tx_data_valid <= 1'b1;
            spi_tx_data       <= rd_err ? 8'h00 : sel_val;
            ch_idx            <= nx_ch;
            byte_idx          <= nx_byte;
         end
         if (wr_start) begin
            wr_err  <= wr_bad;
            wr_addr <= op_addr[WW-1:0];
         end
         if (wr_byte && !wr_err) begin
            for (int i = 0; i < NUM_WR; i++) begin
               if (wr_addr == WW'(i)) begin
                  wr_regs[i*8 +: 8] <= spi_rx_data;
                  wr_strobe[i]      <= 1'b1;
               end
            end
            wr_addr <= wr_addr_nx;
         end
         if (err_hit && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule
